// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: FSM state encodings and
// elaboration-time sizing helpers.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_SNZ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_press_det.sv
// Push-button front end: two-flop synchronizer followed by a registered
// falling-edge detector, giving one pulse per press regardless of hold time.
module key_press_det (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iKEY,
    output logic oPRESS
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic press_r;

    // Synchronize the raw pin and flag its high-to-low transition.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            press_r <= 1'b0;
        end else begin
            sync1_r <= iKEY;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            press_r <= prev_r & ~sync2_r;
        end
    end

    assign oPRESS = press_r;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm ringing-session controller: turns an alarm match into a beeping
// session with stop/snooze keys, a snooze budget and a ring timeout.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int SNOOZE_S    = 300,
    parameter int RING_S      = 60,
    parameter int MAX_SNOOZE  = 3,
    parameter int BEEP_PERIOD = 10,
    parameter int BEEP_ON     = 5
) (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic       iEN_1S,
    input  logic       iEN_100MS,
    input  logic       iMATCH,
    input  logic       iARM,
    input  logic       iKEY_STOP,
    input  logic       iKEY_SNZ,
    output logic       oBUZZ,
    output logic       oRING,
    output logic       oMISSED,
    output logic [1:0] oSTATE,
    output logic [1:0] oSNZ_CNT
);

    localparam int SEC_W = max2(1, clog2(max2(SNOOZE_S, RING_S)));
    localparam int PH_W  = max2(1, clog2(BEEP_PERIOD));

    localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_S - 1);
    localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_S - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BEEP_PERIOD - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

    logic              stop_press_s;
    logic              snz_press_s;
    logic              match_rise_s;
    logic [PH_W-1:0]   phase_inc_s;

    state_t            state_r;
    logic [SEC_W-1:0]  sec_cnt_r;
    logic [PH_W-1:0]   phase_r;
    logic              buzz_r;
    logic              ring_r;
    logic              missed_r;
    logic [1:0]        snz_cnt_r;
    logic              match_prev_r;
    logic              match_valid_r;

    key_press_det u_key_stop (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iKEY   (iKEY_STOP),
        .oPRESS (stop_press_s)
    );

    key_press_det u_key_snz (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iKEY   (iKEY_SNZ),
        .oPRESS (snz_press_s)
    );

    function automatic logic beep_level(input logic [PH_W-1:0] phase);
        return ({1'b0, phase} < (PH_W + 1)'(BEEP_ON));
    endfunction

    // Next beep phase and qualified match rising edge.
    always_comb begin
        phase_inc_s  = '0;
        match_rise_s = 1'b0;
        if (phase_r == PH_LAST) begin
            phase_inc_s = '0;
        end else begin
            phase_inc_s = phase_r + PH_W'(1);
        end
        // A level already high when reset releases has no real previous
        // sample, so edge detection waits for one valid history flop.
        match_rise_s = iMATCH & ~match_prev_r & match_valid_r;
    end

    // Match history for rising-edge detection.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            match_prev_r  <= 1'b0;
            match_valid_r <= 1'b0;
        end else begin
            match_prev_r  <= iMATCH;
            match_valid_r <= 1'b1;
        end
    end

    // Session FSM with its second/phase counters and registered outputs.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_r   <= ST_IDLE;
            sec_cnt_r <= '0;
            phase_r   <= '0;
            buzz_r    <= 1'b0;
            ring_r    <= 1'b0;
            missed_r  <= 1'b0;
            snz_cnt_r <= 2'd0;
        end else if (!iARM) begin
            state_r   <= ST_IDLE;
            sec_cnt_r <= '0;
            phase_r   <= '0;
            buzz_r    <= 1'b0;
            ring_r    <= 1'b0;
            missed_r  <= 1'b0;
            snz_cnt_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    buzz_r <= 1'b0;
                    ring_r <= 1'b0;
                    if (match_rise_s) begin
                        state_r   <= ST_RING;
                        ring_r    <= 1'b1;
                        buzz_r    <= beep_level('0);
                        missed_r  <= 1'b0;
                        sec_cnt_r <= '0;
                        phase_r   <= '0;
                    end
                end
                ST_RING: begin
                    if (stop_press_s) begin
                        state_r <= ST_DONE;
                        buzz_r  <= 1'b0;
                        ring_r  <= 1'b0;
                    end else if (snz_press_s && (snz_cnt_r < SNZ_MAX)) begin
                        state_r   <= ST_SNZ;
                        snz_cnt_r <= snz_cnt_r + 2'd1;
                        sec_cnt_r <= '0;
                        buzz_r    <= 1'b0;
                    end else if (iEN_1S && (sec_cnt_r == RING_LAST)) begin
                        state_r  <= ST_DONE;
                        missed_r <= 1'b1;
                        buzz_r   <= 1'b0;
                        ring_r   <= 1'b0;
                    end else begin
                        if (iEN_1S) begin
                            sec_cnt_r <= sec_cnt_r + SEC_W'(1);
                        end
                        if (iEN_100MS) begin
                            phase_r <= phase_inc_s;
                            buzz_r  <= beep_level(phase_inc_s);
                        end
                    end
                end
                ST_SNZ: begin
                    buzz_r <= 1'b0;
                    if (stop_press_s) begin
                        state_r <= ST_DONE;
                        ring_r  <= 1'b0;
                    end else if (iEN_1S && (sec_cnt_r == SNZ_LAST)) begin
                        state_r   <= ST_RING;
                        sec_cnt_r <= '0;
                        phase_r   <= '0;
                        buzz_r    <= beep_level('0);
                    end else if (iEN_1S) begin
                        sec_cnt_r <= sec_cnt_r + SEC_W'(1);
                    end
                end
                ST_DONE: begin
                    buzz_r <= 1'b0;
                    ring_r <= 1'b0;
                    if (!iMATCH) begin
                        state_r   <= ST_IDLE;
                        snz_cnt_r <= 2'd0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    sec_cnt_r <= '0;
                    phase_r   <= '0;
                    buzz_r    <= 1'b0;
                    ring_r    <= 1'b0;
                    snz_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign oBUZZ    = buzz_r;
    assign oRING    = ring_r;
    assign oMISSED  = missed_r;
    assign oSTATE   = state_r;
    assign oSNZ_CNT = snz_cnt_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with compressed timing parameters; each task
// drives one scenario and compares outputs against hand-derived values.
module tb_alarm_ctrl;

    logic       clk;
    logic       rstn;
    logic       en_1s;
    logic       en_100ms;
    logic       match;
    logic       arm;
    logic       key_stop;
    logic       key_snz;
    logic       buzz;
    logic       ring;
    logic       missed;
    logic [1:0] state;
    logic [1:0] snz_cnt;

    int vectors = 0;
    int errors  = 0;

    alarm_ctrl #(
        .SNOOZE_S    (3),
        .RING_S      (5),
        .MAX_SNOOZE  (2),
        .BEEP_PERIOD (4),
        .BEEP_ON     (2)
    ) dut (
        .iCLK      (clk),
        .iRSTn     (rstn),
        .iEN_1S    (en_1s),
        .iEN_100MS (en_100ms),
        .iMATCH    (match),
        .iARM      (arm),
        .iKEY_STOP (key_stop),
        .iKEY_SNZ  (key_snz),
        .oBUZZ     (buzz),
        .oRING     (ring),
        .oMISSED   (missed),
        .oSTATE    (state),
        .oSNZ_CNT  (snz_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_1s(input int n);
        repeat (n) begin
            en_1s = 1'b1;
            @(negedge clk);
            en_1s = 1'b0;
        end
    endtask

    task automatic tick_100ms;
        en_100ms = 1'b1;
        @(negedge clk);
        en_100ms = 1'b0;
    endtask

    // Press keys and wait until the FSM has reacted (sync + edge + FSM).
    task automatic keys_down(input bit stop, input bit snz);
        if (stop) key_stop = 1'b0;
        if (snz)  key_snz  = 1'b0;
        cyc(4);
    endtask

    task automatic keys_up;
        key_stop = 1'b1;
        key_snz  = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset;
        rstn = 1'b0; match = 1'b1; arm = 1'b1;
        key_stop = 1'b0; key_snz = 1'b0;
        en_1s = 1'b0; en_100ms = 1'b0;
        cyc(3);
        vectors++;
        if ({state, buzz, ring, missed, snz_cnt} !== 7'b0) begin
            $display("FAIL reset_outputs: got state=%0d buzz=%b ring=%b missed=%b snz=%0d, want all 0",
                     state, buzz, ring, missed, snz_cnt);
            errors++;
        end
        rstn = 1'b1; key_stop = 1'b1; key_snz = 1'b1;
        cyc(3);
        vectors++;
        if (state !== 2'd0) begin
            $display("FAIL reset_release_match_high: got state=%0d, want 0", state);
            errors++;
        end
        match = 1'b0;
        cyc(1);
    endtask

    task automatic test_ring_timeout;
        logic exp_buzz [5];
        exp_buzz = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        match = 1'b1;
        cyc(1);
        vectors++;
        if (state !== 2'd1 || buzz !== 1'b1 || ring !== 1'b1) begin
            $display("FAIL ring_entry: got state=%0d buzz=%b ring=%b, want 1 1 1", state, buzz, ring);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            tick_100ms();
            vectors++;
            if (buzz !== exp_buzz[i]) begin
                $display("FAIL beep_pattern[%0d]: got %b, want %b", i, buzz, exp_buzz[i]);
                errors++;
            end
        end
        tick_1s(4);
        vectors++;
        if (state !== 2'd1) begin
            $display("FAIL ring_before_timeout: got state=%0d, want 1", state);
            errors++;
        end
        tick_1s(1);
        vectors++;
        if (state !== 2'd3 || missed !== 1'b1 || buzz !== 1'b0 || ring !== 1'b0) begin
            $display("FAIL ring_timeout: got state=%0d missed=%b buzz=%b ring=%b, want 3 1 0 0",
                     state, missed, buzz, ring);
            errors++;
        end
        match = 1'b0;
        cyc(1);
        vectors++;
        if (state !== 2'd0 || missed !== 1'b1) begin
            $display("FAIL missed_sticky: got state=%0d missed=%b, want 0 1", state, missed);
            errors++;
        end
    endtask

    task automatic test_snooze_count;
        match = 1'b1;
        cyc(1);
        match = 1'b0;
        vectors++;
        if (state !== 2'd1 || missed !== 1'b0) begin
            $display("FAIL ring_clears_missed: got state=%0d missed=%b, want 1 0", state, missed);
            errors++;
        end
        keys_down(1'b0, 1'b1);
        vectors++;
        if (state !== 2'd2 || snz_cnt !== 2'd1 || buzz !== 1'b0 || ring !== 1'b1) begin
            $display("FAIL snooze1: got state=%0d snz=%0d buzz=%b ring=%b, want 2 1 0 1",
                     state, snz_cnt, buzz, ring);
            errors++;
        end
        keys_up();
        tick_1s(2);
        vectors++;
        if (state !== 2'd2) begin
            $display("FAIL snooze_hold: got state=%0d, want 2", state);
            errors++;
        end
        tick_1s(1);
        vectors++;
        if (state !== 2'd1 || buzz !== 1'b1) begin
            $display("FAIL snooze_expire: got state=%0d buzz=%b, want 1 1", state, buzz);
            errors++;
        end
        keys_down(1'b0, 1'b1);
        keys_up();
        tick_1s(3);
        vectors++;
        if (state !== 2'd1 || snz_cnt !== 2'd2) begin
            $display("FAIL snooze2: got state=%0d snz=%0d, want 1 2", state, snz_cnt);
            errors++;
        end
        keys_down(1'b0, 1'b1);
        vectors++;
        if (state !== 2'd1 || snz_cnt !== 2'd2) begin
            $display("FAIL snooze_limit: got state=%0d snz=%0d, want 1 2", state, snz_cnt);
            errors++;
        end
        keys_up();
        keys_down(1'b1, 1'b0);
        vectors++;
        if (state !== 2'd3) begin
            $display("FAIL stop_press: got state=%0d, want 3", state);
            errors++;
        end
        keys_up();
        vectors++;
        if (state !== 2'd0 || snz_cnt !== 2'd0) begin
            $display("FAIL done_to_idle: got state=%0d snz=%0d, want 0 0", state, snz_cnt);
            errors++;
        end
    endtask

    task automatic test_simultaneous_keys;
        match = 1'b1;
        cyc(1);
        match = 1'b0;
        keys_down(1'b0, 1'b1);
        keys_up();
        tick_1s(3);
        keys_down(1'b1, 1'b1);
        vectors++;
        if (state !== 2'd3 || snz_cnt !== 2'd1) begin
            $display("FAIL stop_and_snooze: got state=%0d snz=%0d, want 3 1", state, snz_cnt);
            errors++;
        end
        keys_up();
    endtask

    task automatic test_held_key;
        match = 1'b1;
        cyc(1);
        key_snz = 1'b0;
        cyc(4);
        tick_1s(3);
        cyc(13);
        vectors++;
        if (state !== 2'd1 || snz_cnt !== 2'd1) begin
            $display("FAIL held_key_single: got state=%0d snz=%0d, want 1 1", state, snz_cnt);
            errors++;
        end
        keys_up();
        keys_down(1'b1, 1'b0);
        keys_up();
        cyc(5);
        vectors++;
        if (state !== 2'd3) begin
            $display("FAIL done_match_high: got state=%0d, want 3", state);
            errors++;
        end
        match = 1'b0;
        cyc(1);
        vectors++;
        if (state !== 2'd0) begin
            $display("FAIL done_match_low: got state=%0d, want 0", state);
            errors++;
        end
        match = 1'b1;
        cyc(1);
        match = 1'b0;
        vectors++;
        if (state !== 2'd1) begin
            $display("FAIL rering: got state=%0d, want 1", state);
            errors++;
        end
    endtask

    task automatic test_abort_arm;
        keys_down(1'b0, 1'b1);
        keys_up();
        arm = 1'b0;
        cyc(1);
        vectors++;
        if (state !== 2'd0 || snz_cnt !== 2'd0 || buzz !== 1'b0 || ring !== 1'b0) begin
            $display("FAIL arm_abort: got state=%0d snz=%0d buzz=%b ring=%b, want 0 0 0 0",
                     state, snz_cnt, buzz, ring);
            errors++;
        end
        arm = 1'b1;
        cyc(1);
    endtask

    task automatic test_abort_reset;
        match = 1'b1;
        cyc(1);
        vectors++;
        if (state !== 2'd1 || buzz !== 1'b1) begin
            $display("FAIL ring_before_reset: got state=%0d buzz=%b, want 1 1", state, buzz);
            errors++;
        end
        rstn = 1'b0;
        cyc(1);
        vectors++;
        if ({state, buzz, ring, missed, snz_cnt} !== 7'b0) begin
            $display("FAIL reset_abort: got state=%0d buzz=%b ring=%b missed=%b snz=%0d, want all 0",
                     state, buzz, ring, missed, snz_cnt);
            errors++;
        end
        rstn = 1'b1;
        match = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze_count();
        test_simultaneous_keys();
        test_held_key();
        test_abort_arm();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
